sample_capture: RTL and testbench
=================================

# sample_capture

Acquisition front end of the oscilloscope. Takes a stream of 8-bit ADC samples, decimates them, and waits for a level/slope trigger. It then records 256 consecutive samples and presents them as a stable, tear-free `data[0:255]` array to the display drawing stage directly downstream. It supports continuous (run) and single-shot acquisition with a post-frame holdoff.

## Interface
- `HOLDOFF_CYCLES`, 1024: clk cycles spent in HOLDOFF after each frame.
- `AUTO_TRIG_SAMPLES`, 512: accepted samples in ARMED before a forced trigger (only with `CAPTURE_AUTO_TRIG_EN`).
- `clk`  in  1  system/pixel clock.
- `rst`  in  1  synchronous, active-high reset.
- `sample_valid`  in  1  `sample` valid this cycle.
- `sample`  in  8  unsigned ADC sample.
- `trig_level`  in  8  trigger threshold.
- `trig_slope`  in  1  0 = rising, 1 = falling.
- `decim`  in  8  keep 1 of every `decim+1` valid samples.
- `run`  in  1  1 = continuous re-arm.
- `arm`  in  1  single-shot arm pulse.
- `data`  out  8 x [0:255]  shadow frame buffer for display.
- `frame_done`  out  1  one-cycle pulse when `data` is updated.
- `busy`  out  1  high in ARMED or FILL.
- `auto_trig`  out  1  last frame was force-triggered.

## Operation
- States: IDLE, ARMED, FILL, HOLDOFF.
- Decimation: `dec_cnt` increments on each `sample_valid`. A sample is "accepted" when `dec_cnt == decim`, and `dec_cnt` then returns to 0. `decim = 0` accepts every valid sample. `dec_cnt` clears on entry to ARMED.
- IDLE -> ARMED when `run = 1` or `arm = 1`. `arm` outside IDLE is ignored.
- ARMED: hold the previous accepted sample `prev`. The first accepted sample after entry only loads `prev`, so it cannot trigger.
  - Rising trigger: `prev < trig_level` and `cur >= trig_level`.
  - Falling trigger: `prev > trig_level` and `cur <= trig_level`.
  - On trigger, `cur` is written to capture index 0 and the block moves to FILL with `wr_idx = 1`.
- FILL: each accepted sample is written to `capture[wr_idx]` and `wr_idx` increments. Writing index 255 completes the frame:
  - the whole capture buffer is copied into `data` in one cycle;
  - `frame_done` pulses;
  - the block goes to HOLDOFF.
- HOLDOFF: counts `HOLDOFF_CYCLES` clk cycles and ignores samples. It then goes to ARMED if `run = 1`, otherwise to IDLE.
- Deasserting `run` during ARMED aborts to IDLE the next cycle. Deasserting it during FILL lets the frame complete.
- `trig_level`, `trig_slope` and `decim` are sampled live; changes apply from the next accepted sample.
- `data` changes only on the frame-completion copy, so the display never sees a partial frame.

## Timing
- Reset values: state IDLE, `data` all 0, capture buffer all 0, `frame_done` 0, `busy` 0, `auto_trig` 0, all counters 0.
- Reset mid-operation discards the partial frame and clears `data`.
- Trigger decision is registered: a triggering sample accepted at cycle N is in `capture[0]` and state = FILL at N+1.
- If the last accepted sample (index 255) arrives at cycle N, `data` holds the new frame and `frame_done = 1` at N+1, for exactly one cycle.
- HOLDOFF lasts exactly `HOLDOFF_CYCLES` cycles. State is ARMED or IDLE at completion cycle + `HOLDOFF_CYCLES` + 1.
- `busy` is a registered decode of the state.
- Arithmetic: `wr_idx` is 8 bits and wraps to 0 only at frame end. `dec_cnt` is 8 bits. The holdoff counter is sized with `$clog2(HOLDOFF_CYCLES+1)`. All comparisons are unsigned.

## Configuration
- `CAPTURE_AUTO_TRIG_EN` defined:
  - ARMED counts accepted samples.
  - After reaching `AUTO_TRIG_SAMPLES` with no trigger, the current sample is force-triggered to index 0.
  - `auto_trig` is set for that frame and cleared by the next real trigger.
  - The counter resets on every ARMED entry.
- Not defined: no timeout logic; ARMED waits indefinitely; `auto_trig` tied to 0.

## Structure
- Shared package `osc_pkg`:
  - `SAMPLE_W = 8` and `BUF_DEPTH = 256`;
  - `capture_state_t` enum (IDLE, ARMED, FILL, HOLDOFF);
  - `sample_buf_t` array typedef, also used by the display stage.
- Sub-module `trigger_detect`: registered `prev`, prev-valid flag, and the slope/level comparison, outputting a `trig_hit` strobe.
- Top level holds the decimator, FSM, capture buffer and shadow buffer.

## Test plan
- **Reset and idle:** assert `rst` 3 cycles -> `data` all 0, `busy = 0`. With `run = 0` and no `arm`, a ramp on `sample` -> state stays IDLE, no `frame_done`.
- **Rising trigger:** `run = 1`, `decim = 0`, `trig_level = 0x80`, `trig_slope = 0`, ramp 0x00..0xFF every cycle -> `data[0] = 0x80`, `data[k] = 0x80 + k` wrapping mod 256, one `frame_done` pulse.
- **Falling trigger with decimation:** `decim = 3`, `trig_slope = 1`, `trig_level = 0x40`, descending ramp -> only every 4th sample is stored, and `data[0]` is the first accepted sample `<= 0x40`.
- **Single shot:** `run = 0`, pulse `arm`, sine input -> exactly one `frame_done`, then IDLE after `HOLDOFF_CYCLES`. A second `arm` during FILL is ignored.
- **Mid-fill reset:** `rst` asserted at `wr_idx = 100` -> `data` cleared, state IDLE, no `frame_done`.
- **Auto trigger (macro on):** constant 0x10 input with `trig_level = 0x80` -> after 512 accepted samples, FILL starts, `auto_trig = 1`, and `data` is all 0x10.

Source files
------------

// File: rtl/osc_pkg.sv
// osc_pkg: shared oscilloscope types and sizes.
//   SAMPLE_W / BUF_DEPTH   ADC sample width and frame length
//   capture_state_t        acquisition FSM states
//   sample_buf_t           one full frame of samples, shared with the display stage
package osc_pkg;
  localparam int SAMPLE_W  = 8;
  localparam int BUF_DEPTH = 256;
  typedef enum logic [1:0] {IDLE, ARMED, FILL, HOLDOFF} capture_state_t;
  typedef logic [SAMPLE_W-1:0] sample_buf_t [0:BUF_DEPTH-1];
endpackage

// File: rtl/trigger_detect.sv
// trigger_detect: level/slope crossing detector over consecutive accepted samples.
//   clk, rst    clock, sync active-high reset
//   en          an accepted sample is present while armed
//   clear       forget the held sample (held low only while armed)
//   cur         current sample
//   level       trigger threshold
//   slope       0 = rising, 1 = falling
//   trig_hit    combinational strobe: cur crosses level relative to the held sample
module trigger_detect
  import osc_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                clear,
  input  logic [SAMPLE_W-1:0] cur,
  input  logic [SAMPLE_W-1:0] level,
  input  logic                slope,
  output logic                trig_hit
);
  logic [SAMPLE_W-1:0] prev;
  logic                prev_ok;
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      prev    <= '0;
      prev_ok <= 1'b0;
    end else if (en) begin
      prev    <= cur;
      prev_ok <= 1'b1;
    end
  end
  // The first accepted sample after arming only primes prev and can never fire.
  assign trig_hit = en && prev_ok &&
                    (slope ? (prev > level && cur <= level) : (prev < level && cur >= level));
endmodule

// File: rtl/sample_capture.sv
// sample_capture: decimating, level/slope-triggered capture of 256-sample frames into a
//   tear-free shadow buffer for the display stage; run (continuous) or arm (single shot),
//   with a fixed holdoff after every frame.
//   Optional forced trigger after AUTO_TRIG_SAMPLES accepted samples: define CAPTURE_AUTO_TRIG_EN.
//   clk, rst          clock, sync active-high reset
//   sample_valid      sample is valid this cycle
//   sample            unsigned ADC sample
//   trig_level        trigger threshold
//   trig_slope        0 = rising, 1 = falling
//   decim             keep 1 of every decim+1 valid samples
//   run / arm         continuous re-arm / single-shot arm pulse
//   data              shadow frame buffer, updated only on frame completion
//   frame_done        one-cycle pulse when data is updated
//   busy              armed or filling
//   auto_trig         last frame was force-triggered
module sample_capture
  import osc_pkg::*;
#(
  parameter int HOLDOFF_CYCLES    = 1024,
  parameter int AUTO_TRIG_SAMPLES = 512
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic [SAMPLE_W-1:0] trig_level,
  input  logic                trig_slope,
  input  logic [7:0]          decim,
  input  logic                run,
  input  logic                arm,
  output sample_buf_t         data,
  output logic                frame_done,
  output logic                busy,
  output logic                auto_trig
);
  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
  localparam int AW = $clog2(AUTO_TRIG_SAMPLES + 1);
`ifdef CAPTURE_AUTO_TRIG_EN
  localparam bit AUTO_EN = 1'b1;
`else
  localparam bit AUTO_EN = 1'b0;
`endif
  capture_state_t state;
  sample_buf_t    capture;
  logic [7:0]     dec_cnt;
  logic [7:0]     wr_idx;
  logic [HW-1:0]  hold_cnt;
  logic [AW-1:0]  at_cnt;
  logic           cont;
  logic           accept;
  logic           armed;
  logic           trig_hit;
  logic           force_trig;
  assign accept = sample_valid && dec_cnt == decim;
  assign armed  = state == ARMED;
  trigger_detect u_trig (
    .clk      (clk),
    .rst      (rst),
    .en       (armed && accept),
    .clear    (!armed),
    .cur      (sample),
    .level    (trig_level),
    .slope    (trig_slope),
    .trig_hit (trig_hit)
  );
  // Accepted-sample count since ARMED entry; folds away entirely when AUTO_EN is 0.
  always_ff @(posedge clk)
    at_cnt <= (rst || !armed) ? '0 : accept ? at_cnt + 1'b1 : at_cnt;
  assign force_trig = AUTO_EN && armed && accept && !trig_hit &&
                      at_cnt == AW'(AUTO_TRIG_SAMPLES - 1);
  // cont records whether this arming came from run; only then does dropping run abort ARMED.
  always_ff @(posedge clk) begin
    frame_done <= 1'b0;
    if (rst) begin
      state     <= IDLE;
      data      <= '{default: '0};
      capture   <= '{default: '0};
      busy      <= 1'b0;
      auto_trig <= 1'b0;
      dec_cnt   <= '0;
      wr_idx    <= '0;
      hold_cnt  <= '0;
      cont      <= 1'b0;
    end else begin
      dec_cnt <= accept ? '0 : sample_valid ? dec_cnt + 1'b1 : dec_cnt;
      case (state)
        IDLE: if (run || arm) begin
          state   <= ARMED;
          busy    <= 1'b1;
          cont    <= run;
          dec_cnt <= '0;
        end
        ARMED: if (cont && !run) begin
          state <= IDLE;
          busy  <= 1'b0;
        end else if (trig_hit || force_trig) begin
          state      <= FILL;
          capture[0] <= sample;
          wr_idx     <= 8'd1;
          auto_trig  <= force_trig;
        end
        FILL: if (accept) begin
          capture[wr_idx] <= sample;
          wr_idx          <= wr_idx + 1'b1;
          if (wr_idx == 8'(BUF_DEPTH - 1)) begin
            // Publish the whole frame at once; the last sample bypasses the capture buffer.
            data                <= capture;
            data[BUF_DEPTH - 1] <= sample;
            frame_done          <= 1'b1;
            state               <= HOLDOFF;
            busy                <= 1'b0;
            hold_cnt            <= '0;
          end
        end
        HOLDOFF: if (hold_cnt == HW'(HOLDOFF_CYCLES - 1)) begin
          state    <= run ? ARMED : IDLE;
          busy     <= run;
          cont     <= run;
          dec_cnt  <= '0;
          hold_cnt <= '0;
        end else begin
          hold_cnt <= hold_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sample_capture.sv
// tb_sample_capture: randomized and directed stimulus against a behavioural frame model.
module tb_sample_capture;
  import osc_pkg::*;
  localparam int HOLD   = 1024;
  localparam int AUTO_N = 512;
`ifdef CAPTURE_AUTO_TRIG_EN
  localparam bit AUTO_EN = 1'b1;
`else
  localparam bit AUTO_EN = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst, sample_valid, trig_slope, run, arm;
  logic [7:0]  sample, trig_level, decim;
  sample_buf_t data;
  logic        frame_done, busy, auto_trig;
  sample_capture #(.HOLDOFF_CYCLES(HOLD), .AUTO_TRIG_SAMPLES(AUTO_N)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample       (sample),
    .trig_level   (trig_level),
    .trig_slope   (trig_slope),
    .decim        (decim),
    .run          (run),
    .arm          (arm),
    .data         (data),
    .frame_done   (frame_done),
    .busy         (busy),
    .auto_trig    (auto_trig)
  );
  always #5 clk = ~clk;
  int   n_chk, n_fail, n_done, ph, wave, vpct, bad, n0;
  bit   chk_on;
  int   m_mode, m_nval, m_nacc, m_hold;
  bit   m_cont, m_auto, m_done, m_acc, m_hit, m_force;
  logic [7:0] m_prev;
  logic [7:0] m_data [0:255];
  logic [7:0] frm [$];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Model: mode 0 idle, 1 armed, 2 filling, 3 holdoff. Decimation is the index of the
  // valid sample since arming taken modulo decim+1; the frame is a queue of accepted samples.
  always @(posedge clk) begin
    m_done = 1'b0;
    if (rst) begin
      m_mode = 0;
      m_auto = 1'b0;
      m_nval = 0;
      frm.delete();
      for (int k = 0; k < 256; k++) m_data[k] = 8'h00;
    end else begin
      m_acc = 1'b0;
      if (sample_valid) begin
        m_acc = (m_nval % (decim + 1)) == decim;
        m_nval++;
      end
      if (m_mode == 0) begin
        if (run || arm) begin
          m_mode = 1; m_cont = run; m_nval = 0; m_nacc = 0;
        end
      end else if (m_mode == 1) begin
        if (m_cont && !run) m_mode = 0;
        else if (m_acc) begin
          m_hit = m_nacc > 0 && (trig_slope ? (m_prev > trig_level && sample <= trig_level)
                                            : (m_prev < trig_level && sample >= trig_level));
          m_force = AUTO_EN && !m_hit && m_nacc + 1 == AUTO_N;
          if (m_hit || m_force) begin
            m_mode = 2; frm.delete(); frm.push_back(sample); m_auto = m_force;
          end else begin
            m_prev = sample; m_nacc++;
          end
        end
      end else if (m_mode == 2) begin
        if (m_acc) begin
          frm.push_back(sample);
          if (frm.size() == 256) begin
            for (int k = 0; k < 256; k++) m_data[k] = frm[k];
            m_done = 1'b1; m_mode = 3; m_hold = HOLD;
          end
        end
      end else begin
        m_hold--;
        if (m_hold == 0) begin
          m_mode = run ? 1 : 0; m_cont = run; m_nval = 0; m_nacc = 0;
        end
      end
    end
  end
  always @(negedge clk) if (chk_on) begin
    if (frame_done === 1'b1) n_done++;
    check("busy", 32'(busy), 32'(m_mode == 1 || m_mode == 2));
    check("frame_done", 32'(frame_done), 32'(m_done));
    check("auto_trig", 32'(auto_trig), 32'(m_auto));
    bad = -1;
    for (int k = 255; k >= 0; k--) if (data[k] !== m_data[k]) bad = k;
    n_chk++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL data[%0d]: got %0h expected %0h at %0t", bad, data[bad], m_data[bad], $time);
    end
  end
  task automatic step();
    @(negedge clk);
    sample_valid = $urandom_range(99) < vpct;
    case (wave)
      0: sample = ph[7:0];
      1: sample = 8'hFF - ph[7:0];
      2: sample = 8'(int'(128.0 + 100.0 * $sin(6.2831853 * real'(ph) / 64.0)));
      3: sample = 8'h10;
      default: sample = 8'($urandom);
    endcase
    if (sample_valid) ph++;
  endtask
  task automatic wait_frame(input string name, input int max);
    int i;
    for (i = 0; i < max; i++) begin
      step();
      if (frame_done) break;
    end
    if (i == max) begin
      n_chk++; n_fail++;
      $display("FAIL %s: got no frame_done expected one within %0d cycles", name, max);
    end
  endtask
  task automatic wait_idle(input int max);
    int i;
    run = 1'b0; arm = 1'b0;
    for (i = 0; i < max && m_mode != 0; i++) step();
    if (m_mode != 0) begin
      n_chk++; n_fail++;
      $display("FAIL idle_timeout: got mode %0d expected 0", m_mode);
    end
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end
  initial begin
    rst = 1'b1; sample_valid = 1'b0; sample = '0; trig_level = '0; trig_slope = 1'b0;
    decim = '0; run = 1'b0; arm = 1'b0; ph = 0; wave = 0; vpct = 100;
    @(posedge clk);
    #1 chk_on = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_data0", 32'(data[0]), 0);
    check("rst_data255", 32'(data[255]), 0);
    rst = 1'b0;
    // idle: ramp with neither run nor arm
    repeat (300) step();
    check("idle_frames", n_done, 0);
    check("idle_busy", 32'(busy), 0);
    // rising trigger, every sample kept
    trig_level = 8'h80; trig_slope = 1'b0; decim = 8'd0; run = 1'b1;
    n0 = n_done;
    wait_frame("rise_frame", 2000);
    run = 1'b0;
    check("rise_d0", 32'(data[0]), 32'h80);
    check("rise_d1", 32'(data[1]), 32'h81);
    check("rise_d128", 32'(data[128]), 32'h00);
    check("rise_d255", 32'(data[255]), 32'h7F);
    wait_idle(3000);
    check("rise_frames", n_done - n0, 1);
    // falling trigger, keep 1 of 4, gappy valid
    wave = 1; vpct = 75; decim = 8'd3; trig_slope = 1'b1; trig_level = 8'h40; run = 1'b1;
    wait_frame("fall_frame", 5000);
    run = 1'b0;
    check("fall_d0_range", 32'(data[0] <= 8'h40 && data[0] > 8'h3C), 1);
    check("fall_step", 32'(8'(data[0] - data[1])), 4);
    check("fall_step_end", 32'(8'(data[254] - data[255])), 4);
    wait_idle(3000);
    // single shot on a sine; a second arm during the fill must be ignored
    wave = 2; vpct = 100; decim = 8'd1; trig_slope = 1'b0; trig_level = 8'h80;
    n0 = n_done;
    arm = 1'b1; step(); arm = 1'b0;
    repeat (300) step();
    arm = 1'b1; step(); arm = 1'b0;
    wait_frame("single_frame", 2000);
    repeat (HOLD + 300) step();
    check("single_frames", n_done - n0, 1);
    check("single_busy", 32'(busy), 0);
    // reset with 100 samples of the frame written
    wave = 0; decim = 8'd0; run = 1'b1;
    for (int i = 0; i < 3000 && !(m_mode == 2 && frm.size() == 100); i++) step();
    check("midfill_reached", frm.size(), 100);
    n0 = n_done;
    rst = 1'b1; run = 1'b0; step(); rst = 1'b0;
    check("midfill_data0", 32'(data[0]), 0);
    check("midfill_data200", 32'(data[200]), 0);
    check("midfill_busy", 32'(busy), 0);
    repeat (300) step();
    check("midfill_frames", n_done - n0, 0);
    // no crossing: ARMED waits, dropping run aborts the next cycle
    wave = 3; run = 1'b1; n0 = n_done;
    repeat (300) step();
    check("wait_busy", 32'(busy), 1);
    check("wait_frames", n_done - n0, 0);
    run = 1'b0; step();
    check("abort_busy", 32'(busy), 0);
`ifdef CAPTURE_AUTO_TRIG_EN
    run = 1'b1;
    wait_frame("auto_frame", 2000);
    run = 1'b0;
    check("auto_flag", 32'(auto_trig), 1);
    check("auto_d0", 32'(data[0]), 32'h10);
    check("auto_d255", 32'(data[255]), 32'h10);
    wait_idle(3000);
`endif
    // randomized traffic with live trigger changes, stray arms and run toggles
    for (int b = 0; b < 3; b++) begin
      decim = 8'(b == 2 ? 3 : b); wave = 4; vpct = 70; run = 1'b1;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(99) < 2) trig_level = 8'($urandom);
        if ($urandom_range(99) < 2) trig_slope = 1'($urandom);
        if ($urandom_range(999) == 0) run = !run;
        arm = $urandom_range(99) == 0;
        step();
      end
      wait_idle(6000);
    end
    check("random_frames_seen", 32'(n_done > 5), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
